// File: rtl/addsub15_pkg.sv
// Shared types and defaults for the 15-bit adder/subtractor response checker.
package addsub15_pkg;

    localparam int unsigned W_DEF     = 15;
    localparam int unsigned CNT_W_DEF = 16;

    typedef enum logic {
        StRun,
        StHalt
    } state_e;

    // One checked vector: applied operands, expected and received results.
    typedef struct packed {
        logic [W_DEF-1:0] a;
        logic [W_DEF-1:0] b;
        logic             sub;
        logic [W_DEF-1:0] exp_s;
        logic [W_DEF-1:0] got_s;
        logic             exp_v;
        logic             got_v;
    } cap_t;

endpackage

// File: rtl/addsub15_result_checker_if.sv
// Vector input and result/readback bundle of the adder response checker.
interface addsub15_result_checker_if
    import addsub15_pkg::*;
#(
    parameter int unsigned W     = W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
);
    logic             vld_i;
    logic [W-1:0]     op_a_i;
    logic [W-1:0]     op_b_i;
    logic             sub_i;
    logic [W-1:0]     dut_s_i;
    logic             dut_v_i;

    logic             rdy_o;
    logic             chk_vld_o;
    logic             chk_pass_o;
    logic [CNT_W-1:0] pass_cnt_o;
    logic [CNT_W-1:0] fail_cnt_o;
    logic             err_o;
    logic [W-1:0]     cap_a_o;
    logic [W-1:0]     cap_b_o;
    logic             cap_sub_o;
    logic [W-1:0]     cap_exp_s_o;
    logic [W-1:0]     cap_got_s_o;
    logic             cap_exp_v_o;
    logic             cap_got_v_o;

    // Stimulus side: applies vectors and reads back results.
    modport master (
        output vld_i, op_a_i, op_b_i, sub_i, dut_s_i, dut_v_i,
        input  rdy_o, chk_vld_o, chk_pass_o, pass_cnt_o, fail_cnt_o, err_o,
        input  cap_a_o, cap_b_o, cap_sub_o, cap_exp_s_o, cap_got_s_o, cap_exp_v_o, cap_got_v_o
    );

    // Checker side.
    modport slave (
        input  vld_i, op_a_i, op_b_i, sub_i, dut_s_i, dut_v_i,
        output rdy_o, chk_vld_o, chk_pass_o, pass_cnt_o, fail_cnt_o, err_o,
        output cap_a_o, cap_b_o, cap_sub_o, cap_exp_s_o, cap_got_s_o, cap_exp_v_o, cap_got_v_o
    );

endinterface

// File: rtl/addsub15_ref_model.sv
// Combinational golden model of the W-bit ripple adder/subtractor.
module addsub15_ref_model #(
    parameter int unsigned W = 15
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         sub_i,
    output logic [W-1:0] exp_s_o,
    output logic         exp_v_o
);
    logic [W-1:0] b_x;
    logic [W:0]   full_sum;
    logic         c_msb_in;

    // A + (B ^ sub) + sub; overflow = carry into MSB xor carry out of MSB.
    always_comb begin
        b_x      = b_i ^ {W{sub_i}};
        full_sum = {1'b0, a_i} + {1'b0, b_x} + {{W{1'b0}}, sub_i};
        // Sum bit = a ^ b ^ carry-in, so the MSB carry-in falls out of the sum.
        c_msb_in = full_sum[W-1] ^ a_i[W-1] ^ b_x[W-1];
        exp_s_o  = full_sum[W-1:0];
        exp_v_o  = c_msb_in ^ full_sum[W];
    end

endmodule

// File: rtl/addsub15_result_checker.sv
// Two-stage response checker: golden compare, saturating counters, first-fail capture.
module addsub15_result_checker
    import addsub15_pkg::*;
#(
    parameter int unsigned W            = W_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter bit          HALT_ON_FAIL = 1'b0
) (
    input logic                       clk,
    input logic                       rst_n,
    input logic                       clr_i,
    addsub15_result_checker_if.slave  bus
);
    logic             accept, done, s1_pass;
    logic [W-1:0]     exp_s;
    logic             exp_v;
    logic             s1_vld_q;
    cap_t             s1_q, s1_d;
    state_e           state_q, state_d;
    logic             chk_vld_q, chk_vld_d, chk_pass_q, chk_pass_d;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;
    logic             err_q, err_d;
    cap_t             cap_q, cap_d;

    addsub15_ref_model #(.W(W)) u_ref (
        .a_i    (bus.op_a_i),
        .b_i    (bus.op_b_i),
        .sub_i  (bus.sub_i),
        .exp_s_o(exp_s),
        .exp_v_o(exp_v)
    );

    // Stage-1 acceptance: a clear reopens the checker in the same cycle.
    always_comb begin
        accept = bus.vld_i && ((state_q == StRun) || clr_i);
        s1_d   = '{a: bus.op_a_i, b: bus.op_b_i, sub: bus.sub_i, exp_s: exp_s,
                   got_s: bus.dut_s_i, exp_v: exp_v, got_v: bus.dut_v_i};
    end

    // Stage-1 register: operands, received and expected results.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_q     <= '0;
        end else begin
            s1_vld_q <= accept;
            if (accept) s1_q <= s1_d;
        end
    end

    // Stage-2 next state: compare, count, flag and capture the first failure.
    always_comb begin
        s1_pass    = (s1_q.got_s == s1_q.exp_s) && (s1_q.got_v == s1_q.exp_v);
        // Halted vectors drain silently; a clear discards a completing result.
        done       = s1_vld_q && (state_q == StRun) && !clr_i;
        chk_vld_d  = done;
        chk_pass_d = done && s1_pass;
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        err_d      = err_q;
        cap_d      = cap_q;
        if (done && s1_pass && (pass_cnt_q != {CNT_W{1'b1}})) begin
            pass_cnt_d = pass_cnt_q + CNT_W'(1);
        end
        if (done && !s1_pass) begin
            if (fail_cnt_q != {CNT_W{1'b1}}) fail_cnt_d = fail_cnt_q + CNT_W'(1);
            if (!err_q) cap_d = s1_q;
            err_d = 1'b1;
        end
        if (clr_i) begin
            pass_cnt_d = '0;
            fail_cnt_d = '0;
            err_d      = 1'b0;
            cap_d      = '0;
        end
    end

    // Stage-2 register and readback state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chk_vld_q  <= 1'b0;
            chk_pass_q <= 1'b0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
            err_q      <= 1'b0;
            cap_q      <= '0;
        end else begin
            chk_vld_q  <= chk_vld_d;
            chk_pass_q <= chk_pass_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            err_q      <= err_d;
            cap_q      <= cap_d;
        end
    end

    // Halt one cycle after a failing strobe, so the vector behind it still counts.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:   if (HALT_ON_FAIL && chk_vld_q && !chk_pass_q) state_d = StHalt;
            StHalt:  state_d = StHalt;
            default: state_d = StRun;
        endcase
        if (clr_i) state_d = StRun;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= StRun;
        else        state_q <= state_d;
    end

    assign bus.rdy_o       = (state_q == StRun);
    assign bus.chk_vld_o   = chk_vld_q;
    assign bus.chk_pass_o  = chk_pass_q;
    assign bus.pass_cnt_o  = pass_cnt_q;
    assign bus.fail_cnt_o  = fail_cnt_q;
    assign bus.err_o       = err_q;
    assign bus.cap_a_o     = cap_q.a;
    assign bus.cap_b_o     = cap_q.b;
    assign bus.cap_sub_o   = cap_q.sub;
    assign bus.cap_exp_s_o = cap_q.exp_s;
    assign bus.cap_got_s_o = cap_q.got_s;
    assign bus.cap_exp_v_o = cap_q.exp_v;
    assign bus.cap_got_v_o = cap_q.got_v;

endmodule

// File: tb/tb_addsub15_result_checker.sv
// Bench for the adder response checker: two instances (free-running 16-bit counters,
// and halt-on-fail with 4-bit counters) fed the same vectors, checked against a model.
module tb_addsub15_result_checker;
    import addsub15_pkg::*;

    typedef struct packed {
        logic [14:0] a;
        logic [14:0] b;
        logic        sub;
        logic [14:0] s;
        logic        v;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic clr;
    bit   cmp_en = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   strobes = 0;

    always #5 clk = ~clk;

    addsub15_result_checker_if #(.W(15), .CNT_W(16)) ifa ();
    addsub15_result_checker_if #(.W(15), .CNT_W(4))  ifb ();

    assign ifb.vld_i   = ifa.vld_i;
    assign ifb.op_a_i  = ifa.op_a_i;
    assign ifb.op_b_i  = ifa.op_b_i;
    assign ifb.sub_i   = ifa.sub_i;
    assign ifb.dut_s_i = ifa.dut_s_i;
    assign ifb.dut_v_i = ifa.dut_v_i;

    addsub15_result_checker #(.W(15), .CNT_W(16), .HALT_ON_FAIL(1'b0)) u_dut_a (
        .clk  (clk),
        .rst_n(rst_n),
        .clr_i(clr),
        .bus  (ifa.slave)
    );

    addsub15_result_checker #(.W(15), .CNT_W(4), .HALT_ON_FAIL(1'b1)) u_dut_b (
        .clk  (clk),
        .rst_n(rst_n),
        .clr_i(clr),
        .bus  (ifb.slave)
    );

    // Two's-complement arithmetic on signed integers: returns {overflow, sum}.
    function automatic logic [15:0] golden(input logic [14:0] a, input logic [14:0] b,
                                           input logic sub);
        int          sa, sb, r;
        logic [31:0] ru;
        logic        v;
        sa = a[14] ? int'(a) - 32768 : int'(a);
        sb = b[14] ? int'(b) - 32768 : int'(b);
        r  = sub ? sa - sb : sa + sb;
        v  = (r > 16383) || (r < -16384);
        ru = r;
        return {v, ru[14:0]};
    endfunction

    function automatic int cnt_max(input int k);
        return (k == 0) ? 65535 : 15;
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s inst%0d at %0t: got=%0h expected=%0h", name, k, $time, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_halt[2], m_inflight[2], m_chk_vld[2], m_chk_pass[2], m_err[2];
    int          m_pass[2], m_fail[2];
    vec_t        m_vec[2], m_cap[2];
    logic [15:0] m_cap_exp[2];

    task automatic model_step();
        vec_t iv;
        bit   completing, ok, halt_next;
        iv = {ifa.op_a_i, ifa.op_b_i, ifa.sub_i, ifa.dut_s_i, ifa.dut_v_i};
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_halt[k] = 0; m_inflight[k] = 0; m_chk_vld[k] = 0; m_chk_pass[k] = 0;
                m_err[k] = 0; m_pass[k] = 0; m_fail[k] = 0; m_cap[k] = '0; m_cap_exp[k] = '0;
            end else begin
                // A vector accepted last edge reports now, unless halted or cleared.
                completing = m_inflight[k] && !m_halt[k] && !clr;
                ok = completing &&
                     (golden(m_vec[k].a, m_vec[k].b, m_vec[k].sub) == {m_vec[k].v, m_vec[k].s});
                halt_next = !clr && (m_halt[k] ||
                            ((k == 1) && m_chk_vld[k] && !m_chk_pass[k]));
                if (clr) begin
                    m_chk_vld[k] = 0; m_chk_pass[k] = 0; m_err[k] = 0;
                    m_pass[k] = 0; m_fail[k] = 0; m_cap[k] = '0; m_cap_exp[k] = '0;
                end else begin
                    m_chk_vld[k]  = completing;
                    m_chk_pass[k] = ok;
                    if (completing && ok && m_pass[k] < cnt_max(k)) m_pass[k]++;
                    if (completing && !ok) begin
                        if (m_fail[k] < cnt_max(k)) m_fail[k]++;
                        if (!m_err[k]) begin
                            m_cap[k]     = m_vec[k];
                            m_cap_exp[k] = golden(m_vec[k].a, m_vec[k].b, m_vec[k].sub);
                        end
                        m_err[k] = 1;
                    end
                end
                m_inflight[k] = ifa.vld_i && (!m_halt[k] || clr);
                if (m_inflight[k]) m_vec[k] = iv;
                m_halt[k] = halt_next;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic cmp_inst(input int k, input logic cv, input logic cp,
                            input logic [31:0] pc, input logic [31:0] fc, input logic er,
                            input logic rd, input logic [14:0] ca, input logic [14:0] cb,
                            input logic cs, input logic [14:0] ces, input logic [14:0] cgs,
                            input logic cev, input logic cgv);
        chk("chk_vld", k, cv, m_chk_vld[k]);
        if (m_chk_vld[k]) chk("chk_pass", k, cp, m_chk_pass[k]);
        chk("pass_cnt", k, pc, m_pass[k]);
        chk("fail_cnt", k, fc, m_fail[k]);
        chk("err", k, er, m_err[k]);
        chk("rdy", k, rd, !m_halt[k]);
        chk("cap_a", k, ca, m_cap[k].a);
        chk("cap_b", k, cb, m_cap[k].b);
        chk("cap_sub", k, cs, m_cap[k].sub);
        chk("cap_exp_s", k, ces, m_cap_exp[k][14:0]);
        chk("cap_got_s", k, cgs, m_cap[k].s);
        chk("cap_exp_v", k, cev, m_cap_exp[k][15]);
        chk("cap_got_v", k, cgv, m_cap[k].v);
    endtask

    // Compare both instances against the model every cycle, away from the clock edge.
    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            cmp_inst(0, ifa.chk_vld_o, ifa.chk_pass_o, 32'(ifa.pass_cnt_o),
                     32'(ifa.fail_cnt_o), ifa.err_o, ifa.rdy_o, ifa.cap_a_o, ifa.cap_b_o,
                     ifa.cap_sub_o, ifa.cap_exp_s_o, ifa.cap_got_s_o, ifa.cap_exp_v_o,
                     ifa.cap_got_v_o);
            cmp_inst(1, ifb.chk_vld_o, ifb.chk_pass_o, 32'(ifb.pass_cnt_o),
                     32'(ifb.fail_cnt_o), ifb.err_o, ifb.rdy_o, ifb.cap_a_o, ifb.cap_b_o,
                     ifb.cap_sub_o, ifb.cap_exp_s_o, ifb.cap_got_s_o, ifb.cap_exp_v_o,
                     ifb.cap_got_v_o);
            if (ifa.chk_vld_o) strobes++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [14:0] a, input logic [14:0] b, input logic sub,
                         input logic [14:0] s, input logic v);
        @(negedge clk);
        ifa.vld_i = 1'b1; ifa.op_a_i = a; ifa.op_b_i = b; ifa.sub_i = sub;
        ifa.dut_s_i = s; ifa.dut_v_i = v;
    endtask

    task automatic drive_good(input logic [14:0] a, input logic [14:0] b, input logic sub);
        logic [15:0] g;
        g = golden(a, b, sub);
        drive(a, b, sub, g[14:0], g[15]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            ifa.vld_i = 1'b0;
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        ifa.vld_i = 1'b0; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        logic [14:0] ra, rb, a10;
        logic        rs;
        logic [15:0] g;
        int          s0;

        rst_n = 1'b0; clr = 1'b0;
        ifa.vld_i = 1'b0; ifa.op_a_i = '0; ifa.op_b_i = '0; ifa.sub_i = 1'b0;
        ifa.dut_s_i = '0; ifa.dut_v_i = 1'b0;
        @(posedge clk);
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state, hand-pinned.
        chk("rst_rdy", 0, ifa.rdy_o, 1);
        chk("rst_pass", 0, 32'(ifa.pass_cnt_o), 0);
        chk("rst_err", 1, ifb.err_o, 0);
        chk("rst_chk_vld", 0, ifa.chk_vld_o, 0);

        // Subtract with overflow: 0x4000 - 0x2004 = 0x1FFC, V=1.
        drive(15'h4000, 15'h2004, 1'b1, 15'h1FFC, 1'b1);
        idle(2);
        chk("sub_ovf_vld", 0, ifa.chk_vld_o, 1);
        chk("sub_ovf_pass", 0, ifa.chk_pass_o, 1);
        chk("sub_ovf_cnt", 0, 32'(ifa.pass_cnt_o), 1);
        chk("sub_ovf_err", 0, ifa.err_o, 0);

        // Same vector with V wrong.
        drive(15'h4000, 15'h2004, 1'b1, 15'h1FFC, 1'b0);
        idle(2);
        chk("inj_pass", 0, ifa.chk_pass_o, 0);
        chk("inj_fail_cnt", 0, 32'(ifa.fail_cnt_o), 1);
        chk("inj_err", 0, ifa.err_o, 1);
        chk("inj_cap_exp_v", 0, ifa.cap_exp_v_o, 1);
        chk("inj_cap_got_v", 0, ifa.cap_got_v_o, 0);
        chk("inj_cap_a", 0, ifa.cap_a_o, 15'h4000);
        idle(1);
        chk("halt_rdy", 1, ifb.rdy_o, 0);

        // Add wrap 0x7FFF + 1 = 0x0000, V=0; then a wrong sum leaves capture alone.
        drive(15'h7FFF, 15'h0001, 1'b0, 15'h0000, 1'b0);
        idle(2);
        chk("wrap_pass", 0, ifa.chk_pass_o, 1);
        chk("wrap_cnt", 0, 32'(ifa.pass_cnt_o), 2);
        drive(15'h7FFF, 15'h0001, 1'b0, 15'h0001, 1'b0);
        idle(2);
        chk("wrap_bad_pass", 0, ifa.chk_pass_o, 0);
        chk("wrap_bad_fail", 0, 32'(ifa.fail_cnt_o), 2);
        chk("cap_kept_a", 0, ifa.cap_a_o, 15'h4000);
        chk("cap_kept_s", 0, ifa.cap_got_s_o, 15'h1FFC);
        chk("halted_cnt", 1, 32'(ifb.pass_cnt_o), 1);

        pulse_clr();
        chk("clr_pass", 0, 32'(ifa.pass_cnt_o), 0);
        chk("clr_err", 0, ifa.err_o, 0);
        chk("clr_cap_a", 0, ifa.cap_a_o, 0);
        chk("clr_rdy", 1, ifb.rdy_o, 1);

        // 1000 back-to-back correct vectors.
        @(posedge clk);
        s0 = strobes;
        for (int i = 0; i < 1000; i++) begin
            ra = 15'($urandom); rb = 15'($urandom); rs = 1'($urandom);
            drive_good(ra, rb, rs);
        end
        idle(2);
        chk("stream_pass", 0, 32'(ifa.pass_cnt_o), 1000);
        chk("stream_sat", 1, 32'(ifb.pass_cnt_o), 15);
        chk("stream_fail", 0, 32'(ifa.fail_cnt_o), 0);
        @(posedge clk);
        chk("stream_strobes", 0, strobes - s0, 1000);

        // Fault at vector 10 of 15; halting instance counts exactly one more.
        pulse_clr();
        a10 = '0;
        for (int i = 1; i <= 15; i++) begin
            ra = 15'($urandom); rb = 15'($urandom); rs = 1'($urandom);
            g = golden(ra, rb, rs);
            if (i == 10) begin
                a10 = ra;
                drive(ra, rb, rs, g[14:0] ^ 15'h0001, g[15]);
            end else begin
                drive(ra, rb, rs, g[14:0], g[15]);
            end
        end
        idle(2);
        chk("halt_pass", 1, 32'(ifb.pass_cnt_o), 10);
        chk("halt_fail", 1, 32'(ifb.fail_cnt_o), 1);
        chk("halt_rdy2", 1, ifb.rdy_o, 0);
        chk("halt_cap_a", 1, ifb.cap_a_o, a10);
        chk("run_pass", 0, 32'(ifa.pass_cnt_o), 14);
        chk("run_fail", 0, 32'(ifa.fail_cnt_o), 1);
        pulse_clr();
        chk("unhalt_rdy", 1, ifb.rdy_o, 1);
        chk("unhalt_pass", 1, 32'(ifb.pass_cnt_o), 0);
        chk("unhalt_fail", 1, 32'(ifb.fail_cnt_o), 0);

        // Clear races a completing (failing) result, while a new vector is accepted.
        drive(15'h1234, 15'h0001, 1'b0, 15'h0000, 1'b0);
        drive_good(15'h0100, 15'h0023, 1'b0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0; ifa.vld_i = 1'b0;
        chk("race_vld", 0, ifa.chk_vld_o, 0);
        chk("race_fail", 0, 32'(ifa.fail_cnt_o), 0);
        chk("race_err", 0, ifa.err_o, 0);
        @(negedge clk);
        chk("race_new_vld", 0, ifa.chk_vld_o, 1);
        chk("race_new_cnt", 0, 32'(ifa.pass_cnt_o), 1);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
